pkt_cell_writer: RTL and testbench
==================================

# pkt_cell_writer

Ingress segmentation stage that sits directly upstream of the shared cell SRAM. It accepts a frame as a stream of 8-byte beats, packs 56 payload bytes per cell, takes cell indices from the free list, and writes linked 64-byte cells (payload plus footer) into SRAM port A. At end of frame it emits a descriptor (head index, byte length) to the queueing stage.

## Interface
Parameters:
- BLOCK_BYTES, 64, cell size in bytes. Payload is BLOCK_BYTES-8 = 56; BEATS_PER_CELL = 7.
- NUM_BLOCKS, 4096, number of cells. ADDR_W = clog2(NUM_BLOCKS).
- LEN_W, 14, width of the frame byte-length counter.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  ingress beat valid.
- in_ready  out  1  ingress beat accepted when in_valid & in_ready.
- in_data  in  64  beat data; byte k = bits [8k+7:8k].
- in_keep  in  8  byte enables. Must be 0xFF on non-last beats. Must be contiguous from bit 0 and non-zero on the last beat.
- in_last  in  1  final beat of frame.
- fl_valid  in  1  free list has an index available.
- fl_idx  in  ADDR_W  free cell index offered.
- fl_pop  out  1  consume fl_idx this cycle.
- mem_we  out  1  SRAM port A write enable.
- mem_addr  out  ADDR_W  SRAM port A address.
- mem_wdata  out  BLOCK_BYTES*8  SRAM port A write data.
- desc_valid  out  1  descriptor valid.
- desc_ready  in  1  descriptor accepted when desc_valid & desc_ready.
- desc_head  out  ADDR_W  index of the first cell of the frame.
- desc_len  out  LEN_W  frame length in bytes.

## Operation
- Cell layout:
  - Payload byte j occupies mem_wdata[8j+7:8j] for j = 0..55.
  - The footer occupies bits [511:448]. footer {next_idx, rsvd[5:0], valid, eop} is packed LSB-aligned at bit 448; the remaining footer bits are 0.
- Footer values:
  - valid = 1 on every written cell.
  - Non-last cell: eop = 0, rsvd = 0, next_idx = index of the following cell.
  - Last cell: eop = 1, next_idx = 0, rsvd = count of valid bytes in the cell (1..56).
  - Unused payload bytes in the last cell are 0.
- FSM:
  - S_HEAD: in_ready=0. fl_pop = fl_valid. On pop: cur_idx <= fl_idx, head <= fl_idx, len <= 0, beat_cnt <= 0, go to S_FILL.
  - S_FILL: in_ready=1. On accepted beat:
    - Store bytes at offset beat_cnt*8.
    - len += popcount(in_keep).
    - If in_last, set eop and go to S_WRITE.
    - Else if beat_cnt==6, go to S_LINK.
    - Else beat_cnt++.
  - S_LINK: in_ready=0. fl_pop = fl_valid. On pop: nxt_idx <= fl_idx, eop=0, go to S_WRITE.
  - S_WRITE: mem_we=1 for exactly one cycle, with mem_addr=cur_idx and mem_wdata = buffer plus footer.
    - If eop, go to S_DESC.
    - Else cur_idx <= nxt_idx, clear the buffer, beat_cnt <= 0, go to S_FILL.
  - S_DESC: desc_valid=1 with desc_head and desc_len held stable. When desc_ready, go to S_HEAD.
- A frame that ends exactly on a cell boundary (in_last on beat 7) writes eop=1 with rsvd=56 and performs no extra pop.
- The free list is popped only in S_HEAD and S_LINK. fl_pop is never asserted when fl_valid=0.
- Frames of 2^LEN_W bytes or more are outside the contract.

## Timing
- Reset:
  - State is S_HEAD.
  - in_ready, fl_pop, mem_we and desc_valid are 0.
  - mem_addr, mem_wdata, desc_head and desc_len are 0.
  - Internal buffer, counters and indices are 0.
- Reset mid-frame: the partial frame is discarded, no write is issued, and popped indices are not returned. The free list is reset on the same rst_n.
- Signal timing:
  - fl_pop and in_ready are combinational decodes of state and fl_valid.
  - fl_idx is sampled on the same edge as the pop.
- Latency:
  - An 8-byte frame with fl_valid=1 and desc_ready=1 takes 4 cycles.
  - Sequence: pop (S_HEAD), beat (S_FILL), write (S_WRITE), descriptor (S_DESC).
  - The next S_HEAD follows on cycle 4.
- Cell throughput is 9 cycles per full non-last cell: 7 fill, 1 link, 1 write.
- Stalls:
  - fl_valid=0 in S_HEAD or S_LINK holds the state with in_ready=0.
  - desc_ready=0 holds S_DESC with the descriptor stable.
- The cell write strictly precedes the descriptor, so a descriptor never references an unwritten cell.

## Test plan
- 8-byte frame, keep=0xFF, fl_idx=5:
  - One write to addr 5 with footer next=0, rsvd=8, valid=1, eop=1.
  - desc head=5, len=8.
- 60-byte frame (7 full beats, then last beat with keep=0x0F), fl_idx 10 then 11:
  - Cell 10: footer next=11, eop=0, rsvd=0.
  - Cell 11: bytes 0-3 = frame bytes 56-59, the rest 0, eop=1, rsvd=4.
  - desc head=10, len=60.
- Exact 56-byte frame:
  - Exactly one pop and one write, with eop=1, rsvd=56.
  - desc len=56.
- fl_valid=0 for 5 cycles on entering S_LINK:
  - in_ready=0, fl_pop=0, mem_we=0 throughout.
  - The write follows 1 cycle after fl_valid rises.
- desc_ready=0 for 3 cycles:
  - desc_valid=1 with head and len stable.
  - in_ready=0, no pop.
  - Return to S_HEAD on the cycle after acceptance.
- rst_n low after 3 beats of a frame:
  - All outputs 0 immediately, no mem_we.
  - The next 8-byte frame produces a clean single cell with rsvd=8.

Source files
------------

// File: rtl/pkt_cell_writer.sv
// pkt_cell_writer: segments an 8-byte-beat ingress frame into linked 64-byte
// cells (56 payload bytes + footer), writes them into SRAM port A using
// indices popped from the free list, then emits a (head, length) descriptor.
module pkt_cell_writer #(
    parameter int BLOCK_BYTES = 64,
    parameter int NUM_BLOCKS  = 4096,
    parameter int LEN_W       = 14,
    localparam int ADDR_W     = $clog2(NUM_BLOCKS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [63:0]              in_data,
    input  logic [7:0]               in_keep,
    input  logic                     in_last,
    input  logic                     fl_valid,
    input  logic [ADDR_W-1:0]        fl_idx,
    output logic                     fl_pop,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [BLOCK_BYTES*8-1:0] mem_wdata,
    output logic                     desc_valid,
    input  logic                     desc_ready,
    output logic [ADDR_W-1:0]        desc_head,
    output logic [LEN_W-1:0]         desc_len
);

    localparam int PAYLOAD_BYTES  = BLOCK_BYTES - 8;
    localparam int PAYLOAD_W      = PAYLOAD_BYTES * 8;
    localparam int BEATS_PER_CELL = PAYLOAD_BYTES / 8;
    localparam int BEAT_W         = $clog2(BEATS_PER_CELL);
    localparam int FOOTER_W       = BLOCK_BYTES * 8 - PAYLOAD_W;

    typedef enum logic [2:0] {
        S_HEAD,
        S_FILL,
        S_LINK,
        S_WRITE,
        S_DESC
    } state_t;

    state_t                 state_q, state_d;
    logic [PAYLOAD_W-1:0]   buf_q, buf_d;
    logic [BEAT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [5:0]             cell_bytes_q, cell_bytes_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [ADDR_W-1:0]      cur_idx_q, cur_idx_d;
    logic [ADDR_W-1:0]      nxt_idx_q, nxt_idx_d;
    logic [ADDR_W-1:0]      head_q, head_d;
    logic                   eop_q, eop_d;

    logic [63:0]            beat_data;
    logic [3:0]             keep_cnt;
    logic [FOOTER_W-1:0]    footer;

    // Zero the disabled bytes of the incoming beat and count the enabled ones
    always_comb begin
        beat_data = '0;
        keep_cnt  = '0;
        for (int k = 0; k < 8; k++) begin
            if (in_keep[k]) begin
                beat_data[8*k +: 8] = in_data[8*k +: 8];
            end
            keep_cnt = keep_cnt + {3'b000, in_keep[k]};
        end
    end

    // Footer: last cell carries its byte count, other cells carry the link
    always_comb begin
        footer              = '0;
        footer[0]           = eop_q;
        footer[1]           = 1'b1;
        footer[7:2]         = eop_q ? cell_bytes_q : 6'd0;
        footer[8 +: ADDR_W] = eop_q ? '0 : nxt_idx_q;
    end

    // Next-state and output decode for the segmentation FSM
    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        beat_cnt_d   = beat_cnt_q;
        cell_bytes_d = cell_bytes_q;
        len_d        = len_q;
        cur_idx_d    = cur_idx_q;
        nxt_idx_d    = nxt_idx_q;
        head_d       = head_q;
        eop_d        = eop_q;
        in_ready     = 1'b0;
        fl_pop       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        desc_valid   = 1'b0;
        desc_head    = '0;
        desc_len     = '0;
        case (state_q)
            S_HEAD: begin
                fl_pop = fl_valid;
                if (fl_valid) begin
                    cur_idx_d    = fl_idx;
                    head_d       = fl_idx;
                    len_d        = '0;
                    beat_cnt_d   = '0;
                    cell_bytes_d = '0;
                    buf_d        = '0;
                    eop_d        = 1'b0;
                    state_d      = S_FILL;
                end
            end
            S_FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    for (int b = 0; b < BEATS_PER_CELL; b++) begin
                        if (beat_cnt_q == BEAT_W'(b)) begin
                            buf_d[64*b +: 64] = beat_data;
                        end
                    end
                    len_d        = len_q + LEN_W'(keep_cnt);
                    cell_bytes_d = cell_bytes_q + 6'(keep_cnt);
                    if (in_last) begin
                        eop_d   = 1'b1;
                        state_d = S_WRITE;
                    end else if (beat_cnt_q == BEAT_W'(BEATS_PER_CELL - 1)) begin
                        state_d = S_LINK;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    end
                end
            end
            S_LINK: begin
                fl_pop = fl_valid;
                if (fl_valid) begin
                    nxt_idx_d = fl_idx;
                    eop_d     = 1'b0;
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = cur_idx_q;
                mem_wdata = {footer, buf_q};
                if (eop_q) begin
                    state_d = S_DESC;
                end else begin
                    cur_idx_d    = nxt_idx_q;
                    buf_d        = '0;
                    beat_cnt_d   = '0;
                    cell_bytes_d = '0;
                    state_d      = S_FILL;
                end
            end
            S_DESC: begin
                desc_valid = 1'b1;
                desc_head  = head_q;
                desc_len   = len_q;
                if (desc_ready) begin
                    state_d = S_HEAD;
                end
            end
            default: begin
                state_d = S_HEAD;
            end
        endcase
    end

    // State and datapath registers; reset drops any partial frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_HEAD;
            buf_q        <= '0;
            beat_cnt_q   <= '0;
            cell_bytes_q <= '0;
            len_q        <= '0;
            cur_idx_q    <= '0;
            nxt_idx_q    <= '0;
            head_q       <= '0;
            eop_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            beat_cnt_q   <= beat_cnt_d;
            cell_bytes_q <= cell_bytes_d;
            len_q        <= len_d;
            cur_idx_q    <= cur_idx_d;
            nxt_idx_q    <= nxt_idx_d;
            head_q       <= head_d;
            eop_q        <= eop_d;
        end
    end

endmodule

// File: tb/tb_pkt_cell_writer.sv
// tb_pkt_cell_writer: directed and randomized frames driven into
// pkt_cell_writer; every cell write and descriptor is compared against cell
// images computed directly from the frame bytes and the offered free indices.
module tb_pkt_cell_writer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_data;
    logic [7:0]   in_keep;
    logic         in_last;
    logic         fl_valid;
    logic [11:0]  fl_idx;
    logic         fl_pop;
    logic         mem_we;
    logic [11:0]  mem_addr;
    logic [511:0] mem_wdata;
    logic         desc_valid;
    logic         desc_ready;
    logic [11:0]  desc_head;
    logic [13:0]  desc_len;

    pkt_cell_writer #(
        .BLOCK_BYTES(64),
        .NUM_BLOCKS (4096),
        .LEN_W      (14)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_keep   (in_keep),
        .in_last   (in_last),
        .fl_valid  (fl_valid),
        .fl_idx    (fl_idx),
        .fl_pop    (fl_pop),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .desc_valid(desc_valid),
        .desc_ready(desc_ready),
        .desc_head (desc_head),
        .desc_len  (desc_len)
    );

    // Free-running 10-time-unit clock
    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [7:0]   frameBytes [0:511];
    logic [11:0]  framePool[$];
    logic [11:0]  popped[$];
    int           popCyc[$];
    logic [11:0]  wrAddr[$];
    logic [511:0] wrData[$];
    int           wrCyc[$];
    bit           descSeen;
    logic [11:0]  descHeadSeen;
    logic [13:0]  descLenSeen;
    int           descCyc;

    // One comparison: counts it, and reports tag/observed/expected on a miss
    task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Fresh random frame bytes and the list of indices the free list will offer
    task automatic prepFrame(input int nbytes, input int firstIdx, input bit randIdx);
        int cells = (nbytes + 55) / 56;
        for (int i = 0; i < 512; i++) frameBytes[i] = 8'($urandom);
        framePool.delete();
        for (int i = 0; i < cells; i++)
            framePool.push_back(randIdx ? 12'($urandom_range(1, 4095)) : 12'(firstIdx + i));
    endtask

    // Drive one frame cycle by cycle, recording pops, writes and the descriptor
    task automatic applyStimulus(input int nbytes, input int linkStall, input int descStall,
                                 input bit gaps, input int abortAfter);
        int          nBeats   = (nbytes + 7) / 8;
        int          beatIdx  = 0;
        int          poolPtr  = 0;
        int          flHold   = 0;
        int          descHold = descStall;
        int          cyc      = 0;
        bit          done     = 1'b0;
        logic [63:0] d;
        logic [7:0]  k;
        popped.delete(); popCyc.delete();
        wrAddr.delete(); wrData.delete(); wrCyc.delete();
        descSeen = 1'b0; descCyc = -1;
        while (!done && cyc < 3000) begin
            for (int kk = 0; kk < 8; kk++) begin
                if (beatIdx * 8 + kk < nbytes) begin
                    d[8*kk +: 8] = frameBytes[beatIdx * 8 + kk];
                    k[kk] = 1'b1;
                end else begin
                    d[8*kk +: 8] = 8'($urandom);
                    k[kk] = 1'b0;
                end
            end
            in_valid   = (beatIdx < nBeats) && (!gaps || $urandom_range(0, 3) != 0);
            in_data    = in_valid ? d : {$urandom, $urandom};
            in_keep    = k;
            in_last    = (beatIdx == nBeats - 1);
            fl_valid   = (flHold == 0) && (poolPtr < framePool.size()) && (!gaps || $urandom_range(0, 3) != 0);
            fl_idx     = (poolPtr < framePool.size()) ? framePool[poolPtr] : 12'($urandom);
            desc_ready = (descHold == 0) && (!gaps || $urandom_range(0, 2) != 0);
            @(negedge clk);
            if (fl_pop) begin
                checkOutput("popNeedsValid", 512'(fl_valid), 512'(1));
                checkOutput("popNotReady", 512'(in_ready), 512'(0));
                popped.push_back(fl_idx);
                popCyc.push_back(cyc);
                poolPtr++;
            end
            if (flHold > 0) begin
                checkOutput("linkStallReady", 512'(in_ready), 512'(0));
                checkOutput("linkStallWe", 512'(mem_we), 512'(0));
                flHold--;
            end
            if (mem_we) begin
                wrAddr.push_back(mem_addr);
                wrData.push_back(mem_wdata);
                wrCyc.push_back(cyc);
            end
            if (desc_valid) begin
                checkOutput("descNotReady", 512'(in_ready), 512'(0));
                checkOutput("descNoPop", 512'(fl_pop), 512'(0));
                checkOutput("descHeadHeld", 512'(desc_head), 512'(framePool[0]));
                checkOutput("descLenHeld", 512'(desc_len), 512'(nbytes));
                if (desc_ready) begin
                    descSeen     = 1'b1;
                    descHeadSeen = desc_head;
                    descLenSeen  = desc_len;
                    descCyc      = cyc;
                    done         = 1'b1;
                end else if (descHold > 0) begin
                    descHold--;
                end
            end
            if (in_valid && in_ready) begin
                beatIdx++;
                if (beatIdx % 7 == 0 && beatIdx < nBeats) flHold = linkStall;
                if (abortAfter > 0 && beatIdx == abortAfter) done = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!done) checkOutput("timeout", 512'(0), 512'(1));
        in_valid   = 1'b0;
        fl_valid   = 1'b0;
        desc_ready = 1'b0;
    endtask

    // Rebuild every expected cell image from the frame bytes and compare
    task automatic verifyFrame(input int nbytes);
        int           cells = (nbytes + 55) / 56;
        logic [511:0] exp;
        checkOutput("popCount", 512'(popped.size()), 512'(cells));
        checkOutput("writeCount", 512'(wrAddr.size()), 512'(cells));
        for (int i = 0; i < cells && i < wrAddr.size(); i++) begin
            exp = '0;
            for (int j = 0; j < 56; j++)
                if (56 * i + j < nbytes) exp[8*j +: 8] = frameBytes[56 * i + j];
            exp[448] = (i == cells - 1);
            exp[449] = 1'b1;
            if (i == cells - 1) exp[455:450] = 6'(nbytes - 56 * i);
            else                exp[456 +: 12] = framePool[i + 1];
            checkOutput("cellAddr", 512'(wrAddr[i]), 512'(framePool[i]));
            checkOutput("cellData", wrData[i], exp);
            checkOutput("writeBeforeDesc", 512'(wrCyc[i] < descCyc), 512'(1));
        end
        checkOutput("descSeen", 512'(descSeen), 512'(1));
        checkOutput("descHead", 512'(descHeadSeen), 512'(framePool[0]));
        checkOutput("descLen", 512'(descLenSeen), 512'(nbytes));
    endtask

    // Every output must read zero while the block sits in reset
    task automatic checkResetOutputs();
        checkOutput("rstInReady", 512'(in_ready), 512'(0));
        checkOutput("rstFlPop", 512'(fl_pop), 512'(0));
        checkOutput("rstMemWe", 512'(mem_we), 512'(0));
        checkOutput("rstDescValid", 512'(desc_valid), 512'(0));
        checkOutput("rstMemAddr", 512'(mem_addr), 512'(0));
        checkOutput("rstMemWdata", mem_wdata, 512'(0));
        checkOutput("rstDescHead", 512'(desc_head), 512'(0));
        checkOutput("rstDescLen", 512'(desc_len), 512'(0));
    endtask

    // Directed steps followed by a randomized frame sweep
    initial begin
        int n;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_keep    = '0;
        in_last    = 1'b0;
        fl_valid   = 1'b0;
        fl_idx     = '0;
        desc_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] single-beat frame at index 5");
        prepFrame(8, 5, 1'b0);
        applyStimulus(8, 0, 0, 1'b0, 0);
        verifyFrame(8);
        checkOutput("lat8Pop", 512'(popCyc[0]), 512'(0));
        checkOutput("lat8Write", 512'(wrCyc[0]), 512'(2));
        checkOutput("lat8Desc", 512'(descCyc), 512'(3));

        $display("[TB] 60-byte frame spanning cells 10 and 11");
        prepFrame(60, 10, 1'b0);
        applyStimulus(60, 0, 0, 1'b0, 0);
        verifyFrame(60);
        checkOutput("lat60Write0", 512'(wrCyc[0]), 512'(9));
        checkOutput("lat60Write1", 512'(wrCyc[1]), 512'(11));

        $display("[TB] exact 56-byte frame");
        prepFrame(56, 20, 1'b0);
        applyStimulus(56, 0, 0, 1'b0, 0);
        verifyFrame(56);
        checkOutput("lat56Write", 512'(wrCyc[0]), 512'(8));

        $display("[TB] free list empty for 5 cycles at the link point");
        prepFrame(64, 30, 1'b0);
        applyStimulus(64, 5, 0, 1'b0, 0);
        verifyFrame(64);
        checkOutput("linkPopCyc", 512'(popCyc[1]), 512'(13));
        checkOutput("linkWriteCyc", 512'(wrCyc[0]), 512'(14));

        $display("[TB] descriptor back-pressure for 3 cycles");
        prepFrame(16, 40, 1'b0);
        applyStimulus(16, 0, 3, 1'b0, 0);
        verifyFrame(16);
        checkOutput("descStallCyc", 512'(descCyc), 512'(7));
        prepFrame(8, 45, 1'b0);
        applyStimulus(8, 0, 0, 1'b0, 0);
        verifyFrame(8);
        checkOutput("headAfterDesc", 512'(popCyc[0]), 512'(0));

        $display("[TB] reset after three beats of a frame");
        prepFrame(40, 50, 1'b0);
        applyStimulus(40, 0, 0, 1'b0, 3);
        checkOutput("abortNoWrite", 512'(wrAddr.size()), 512'(0));
        rst_n = 1'b0;
        #1;
        checkResetOutputs();
        repeat (2) begin
            @(negedge clk);
            checkOutput("rstHeldMemWe", 512'(mem_we), 512'(0));
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        prepFrame(8, 60, 1'b0);
        applyStimulus(8, 0, 0, 1'b0, 0);
        verifyFrame(8);

        $display("[TB] randomized frames");
        for (int r = 0; r < 12; r++) begin
            n = $urandom_range(1, 300);
            prepFrame(n, 0, 1'b1);
            applyStimulus(n, $urandom_range(0, 3), $urandom_range(0, 2), 1'b1, 0);
            verifyFrame(n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
